if_stage: RTL and testbench

Instruction-fetch stage of the RV32I core. Holds the program counter, issues one instruction-memory request at a time, and presents the fetched word to decode through a valid/ready handshake. It also pre-splits the word into the 25-bit `field` (`instr[31:7]`) and 2-bit `select` (`instr[6:5]`) that the immediate generator consumes directly. It redirects on branch/jump targets from execute.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Definitions shared across the RV32I core: fetch FSM states, the canonical
// NOP encoding, the default reset PC and base opcodes used by decode.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// presents the fetched word to decode through a valid/ready handshake.
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [24:0] id_imm_field,
    output logic [1:0]  id_imm_sel
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         drop_q;
    logic         id_valid_q;
    logic [31:0]  id_pc_q;
    logic [31:0]  id_instr_q;

    logic [31:0]  redir_pc_d;
    logic [31:0]  pc_inc_d;
    logic         unused_redirect_lsb;

    assign redir_pc_d          = {redirect_pc[31:2], 2'b00};
    assign pc_inc_d            = pc_q + 32'd4;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // drop_q marks a granted response that must be swallowed after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_instr_q <= INSTR_NOP;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    if (redirect_valid) pc_q <= redir_pc_d;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                        if (imem_gnt) begin
                            state_q <= WAIT;
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_gnt) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                        if (imem_rvalid) begin
                            state_q <= REQ;
                            drop_q  <= 1'b0;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            id_instr_q <= imem_rdata;
                            id_pc_q    <= pc_q;
                            pc_q       <= pc_inc_d;
                            id_valid_q <= 1'b1;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_q       <= redir_pc_d;
                        id_valid_q <= 1'b0;
                        state_q    <= REQ;
                    end else if (id_ready) begin
                        id_valid_q <= 1'b0;
                        state_q    <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_instr     = id_instr_q;
    assign id_imm_field = id_instr_q[31:7];
    assign id_imm_sel   = id_instr_q[6:5];

endmodule

// File: tb/tb_if_stage.sv
// Scenario bench for if_stage: a latency-configurable memory model feeds a
// scoreboard of expected {pc, instr} pairs that is checked at each handshake.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [24:0] id_imm_field;
    logic [1:0]  id_imm_sel;

    if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instr(id_instr), .id_imm_field(id_imm_field), .id_imm_sel(id_imm_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;

    logic        rdy_en = 1'b0;
    logic        redir_en = 1'b0;
    logic [31:0] redir_target = 32'h0;
    int          gnt_wait = 0;
    int          rv_wait = 1;

    logic        m_pend = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt = 0;
    int          req_cnt = 0;
    logic [63:0] sb_q[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One cycle: drive inputs at the falling edge, run memory model and scoreboard
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        id_ready       = rdy_en;
        redirect_valid = redir_en;
        redirect_pc    = redir_target;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        if (m_pend) begin
            if (redir_en) m_drop = 1'b1;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(m_addr);
                if (!m_drop) sb_q.push_back({m_addr, word(m_addr)});
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (imem_req && rst_n) begin
            if (req_cnt >= gnt_wait) begin
                imem_gnt = 1'b1;
                m_pend   = 1'b1;
                m_addr   = imem_addr;
                m_cnt    = rv_wait - 1;
                m_drop   = redir_en;
                req_cnt  = 0;
            end else begin
                req_cnt++;
            end
        end else begin
            req_cnt = 0;
        end
        if (id_valid && id_ready && !redir_en) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no valid", id_pc, id_instr);
            end else begin
                e = sb_q.pop_front();
                pops++;
                if (id_pc !== e[63:32] || id_instr !== e[31:0] ||
                    id_imm_field !== e[31:7] || id_imm_sel !== e[6:5]) begin
                    errors++;
                    $display("FAIL sb_data: got pc=%h instr=%h field=%h sel=%b, required pc=%h instr=%h",
                             id_pc, id_instr, id_imm_field, id_imm_sel, e[63:32], e[31:0]);
                end
            end
        end else if (id_valid && redir_en && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic run_until_pops(input int n);
        int target = pops + n;
        int budget = 60 * n;
        while (pops < target && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (pops < target) begin
            errors++;
            $display("FAIL timeout_pops: got %0d handshakes, required %0d", pops, target);
        end
    endtask

    task automatic wait_gnt();
        int budget = 40;
        tick();
        while (!imem_gnt && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (!imem_gnt) begin
            errors++;
            $display("FAIL timeout_gnt: got no grant, required one");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_imem: got req=%b addr=%h, required 0/00000000", imem_req, imem_addr);
        end
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_id: got valid=%b pc=%h, required 0/00000000", id_valid, id_pc);
        end
        checks++;
        if (id_instr !== 32'h0000_0013 || id_imm_field !== 25'h0 || id_imm_sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_instr: got %h, required 00000013", id_instr);
        end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_req_early: got req=%b, required 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_valid_early: got %b, required 0", id_valid);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_imm_field !== 25'h00A001 || id_imm_sel !== 2'b00) begin
            errors++;
            $display("FAIL first_valid: got valid=%b pc=%h field=%h sel=%b, required 1/0/00a001/00",
                     id_valid, id_pc, id_imm_field, id_imm_sel);
        end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0050_0093 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%b pc=%h instr=%h req=%b, required 1/0/00500093/0",
                         i, id_valid, id_pc, id_instr, imem_req);
            end
        end
        rdy_en = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL hold_next_req: got req=%b addr=%h, required 1/00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        gnt_wait = 0;
        rv_wait  = 1;
        run_until_pops(1);
        t0 = cyc;
        run_until_pops(3);
        checks++;
        if (cyc - t0 !== 9) begin
            errors++;
            $display("FAIL throughput: got %0d cycles for 3 instrs, required 9", cyc - t0);
        end
        gnt_wait = 2;
        rv_wait  = 3;
        run_until_pops(3);
    endtask

    task automatic test_redirect_wait();
        bit seen = 0;
        gnt_wait = 0;
        rv_wait  = 3;
        wait_gnt();
        redir_en = 1'b1;
        redir_target = 32'h0000_0102;
        tick();
        redir_en = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (id_valid) begin
                checks++;
                errors++;
                $display("FAIL redir_wait_valid: got id_valid=1 pc=%h, required 0", id_pc);
            end
            if (imem_req) seen = 1;
        end
        checks++;
        if (!seen || imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redir_wait_addr: got req=%b addr=%h, required 1/00000100", seen, imem_addr);
        end
        run_until_pops(1);
    endtask

    task automatic test_redirect_gnt();
        bit seen = 0;
        gnt_wait = 0;
        rv_wait  = 1;
        run_until_pops(1);
        redir_en = 1'b1;
        redir_target = 32'h0000_0200;
        tick();
        redir_en = 1'b0;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redir_gnt_req: got req=%b, required 1", imem_req);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (id_valid) begin
                checks++;
                errors++;
                $display("FAIL redir_gnt_valid: got id_valid=1 pc=%h, required 0", id_pc);
            end
            if (imem_req) seen = 1;
        end
        checks++;
        if (!seen || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL redir_gnt_addr: got req=%b addr=%h, required 1/00000200", seen, imem_addr);
        end
        run_until_pops(1);
    endtask

    task automatic test_wrap();
        int budget = 40;
        rdy_en = 1'b0;
        tick();
        while (!id_valid && budget > 0) begin
            tick();
            budget--;
        end
        redir_en = 1'b1;
        redir_target = 32'hFFFF_FFFE;
        tick();
        redir_en = 1'b0;
        tick();
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL redir_hold: got valid=%b req=%b addr=%h, required 0/1/fffffffc",
                     id_valid, imem_req, imem_addr);
        end
        rdy_en = 1'b1;
        run_until_pops(1);
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
        end
        run_until_pops(1);
    endtask

    task automatic test_reset_mid_wait();
        gnt_wait = 0;
        rv_wait  = 3;
        wait_gnt();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0 ||
            id_pc !== 32'h0 || id_instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_async: got req=%b addr=%h valid=%b pc=%h instr=%h, required reset values",
                     imem_req, imem_addr, id_valid, id_pc, id_instr);
        end
        m_drop = 1'b1;
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        rv_wait = 1;
        run_until_pops(2);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
